ps2_keyboard_port: RTL

- Receives a PS/2 keyboard serial stream (scan-code set 2) and produces the 32-bit keyboard_data word consumed by the Frogger processor.
- Synchronises the PS/2 lines and deserialises 11-bit frames.
- Decodes E0/F0 prefixes, tracks held state of the game keys, and exposes a rolling event counter the program polls.
- Sits between the board PS/2 pins and the system-top keyboard_data input.

---
 rtl/ps2_keyboard_port.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_keyboard_port.sv
// ps2_keyboard_port: PS/2 keyboard receiver (scan-code set 2) for the Frogger
// processor. It synchronises the PS/2 pins and deserialises 11-bit frames.
// It decodes the E0/F0 prefixes and tracks the held game keys.
// The results are packed into the 32-bit keyboard_data status word.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_keyboard_port #(
  parameter int bus            = 32,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  output logic [bus-1:0] keyboard_data,
  output logic           key_valid
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Held-key table: index 0..4 = up, down, left, right, space (word bits 16..20)
  localparam logic [39:0] KEY_CODES = {8'h29, 8'h74, 8'h6B, 8'h72, 8'h75};
  localparam logic [4:0]  KEY_EXT   = 5'b01111;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic [2:0]    ps2_clk_sync_reg;
  logic [1:0]    ps2_data_sync_reg;
  logic          sync_data;
  logic          fall;

  state_t        state_reg, state_next;
  logic [3:0]    bit_cnt_reg, bit_cnt_next;
  logic [8:0]    shreg_reg, shreg_next;
  logic          stop_reg, stop_next;
  logic [TW-1:0] timer_reg, timer_next;

  logic          parity_ok;
  logic          byte_good;
  logic          byte_bad;
  logic [7:0]    rx_byte;
  logic          is_e0, is_f0;

  logic          ext_flag_reg, brk_flag_reg;
  logic [7:0]    code_reg;
  logic          ext_bit_reg, brk_bit_reg;
  logic [4:0]    held_reg, held_next;
  logic [7:0]    evt_cnt_reg;
  logic          err_reg;
  logic          key_valid_reg;

  // Two-flop synchronisers; the third ps2_clk flop supplies the previous level for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps2_clk_sync_reg  <= '1;
      ps2_data_sync_reg <= '1;
    end else begin
      ps2_clk_sync_reg  <= {ps2_clk_sync_reg[1:0], ps2_clk};
      ps2_data_sync_reg <= {ps2_data_sync_reg[0], ps2_data};
    end
  end

  assign sync_data = ps2_data_sync_reg[1];
  assign fall      = ps2_clk_sync_reg[2] & ~ps2_clk_sync_reg[1];

  // Frame FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shreg_reg   <= '0;
      stop_reg    <= 1'b0;
      timer_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shreg_reg   <= shreg_next;
      stop_reg    <= stop_next;
      timer_reg   <= timer_next;
    end
  end

  // Frame FSM next state: start bit, 8 data bits LSB-first plus parity, then stop bit
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shreg_next   = shreg_reg;
    stop_next    = stop_reg;
    timer_next   = timer_reg;
    case (state_reg)
      IDLE: begin
        if (fall && !sync_data) begin
          state_next   = SHIFT;
          bit_cnt_next = '0;
          timer_next   = '0;
        end
      end
      SHIFT: begin
        if (fall) begin
          timer_next = '0;
          if (bit_cnt_reg == 4'd9) begin
            stop_next  = sync_data;
            state_next = CHECK;
          end else begin
            shreg_next   = {sync_data, shreg_reg[8:1]};
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
        end else if (timer_reg == TW'(TIMEOUT_CYCLES - 1)) begin
          state_next = IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      CHECK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^shreg_reg;
`else
  assign parity_ok = 1'b1;
`endif

  assign byte_good = (state_reg == CHECK) &  (stop_reg & parity_ok);
  assign byte_bad  = (state_reg == CHECK) & ~(stop_reg & parity_ok);
  assign rx_byte   = shreg_reg[7:0];
  assign is_e0     = (rx_byte == 8'hE0);
  assign is_f0     = (rx_byte == 8'hF0);

  // Per-key held state: a matching make sets the bit, a matching break clears it
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_held
      logic key_match;
      assign key_match     = (rx_byte == KEY_CODES[gi*8 +: 8]) && (ext_flag_reg || !KEY_EXT[gi]);
      assign held_next[gi] = key_match ? ~brk_flag_reg : held_reg[gi];
    end
  endgenerate

  // Decoder: prefixes arm flags, any other good byte is a key event
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ext_flag_reg  <= 1'b0;
      brk_flag_reg  <= 1'b0;
      code_reg      <= '0;
      ext_bit_reg   <= 1'b0;
      brk_bit_reg   <= 1'b0;
      held_reg      <= '0;
      evt_cnt_reg   <= '0;
      err_reg       <= 1'b0;
      key_valid_reg <= 1'b0;
    end else begin
      key_valid_reg <= 1'b0;
      if (byte_bad) begin
        err_reg <= 1'b1;
      end
      if (byte_good) begin
        if (is_e0) begin
          ext_flag_reg <= 1'b1;
        end else if (is_f0) begin
          brk_flag_reg <= 1'b1;
        end else begin
          code_reg      <= rx_byte;
          ext_bit_reg   <= ext_flag_reg;
          brk_bit_reg   <= brk_flag_reg;
          held_reg      <= held_next;
          evt_cnt_reg   <= evt_cnt_reg + 8'd1;
          key_valid_reg <= 1'b1;
          ext_flag_reg  <= 1'b0;
          brk_flag_reg  <= 1'b0;
        end
      end
    end
  end

  // Status word assembly; any bits above 31 read as zero
  always_comb begin
    keyboard_data       = '0;
    keyboard_data[31:0] = {evt_cnt_reg, 3'b000, held_reg, 5'b00000,
                           err_reg, brk_bit_reg, ext_bit_reg, code_reg};
  end

  assign key_valid = key_valid_reg;

endmodule
